// File: rtl/sqrt_pipelined_stream.sv
// ---------------------------------------------------------------------------
// sqrt_pipelined_stream
//
// Fully pipelined unsigned integer / fixed-point square root. The radicand is
// scaled by 4^FRAC_BITS and processed by a non-restoring digit recurrence that
// produces one root bit per stage, MSB first. Every stage carries its own
// valid bit. The whole pipeline advances together whenever the output register
// is empty or being consumed, so a stalled consumer freezes every stage.
//
// Optional feature (define the macro to enable):
//   SQRT_PIPELINED_ROUND_EN - adds one registered stage that rounds the root to
//                             nearest (T+1 when remainder > T, saturating at
//                             all-ones). The remainder still refers to the
//                             truncated root T.
//
// Parameters:
//   INPUT_BITS  - radicand width (>= 2); odd widths are zero-extended by one bit
//   FRAC_BITS   - number of fractional root bits
//   OUTPUT_BITS - derived root width = (INPUT_BITS+1)/2 + FRAC_BITS
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   in_valid  in   radicand offered
//   in_ready  out  radicand accepted when in_valid & in_ready
//   radicand  in   [INPUT_BITS-1:0] unsigned operand
//   out_valid out  result present
//   out_ready in   consumer accepts result when out_valid & out_ready
//   root      out  [OUTPUT_BITS-1:0] root, FRAC_BITS fraction bits
//   remainder out  [OUTPUT_BITS:0] X - T*T, X = radicand*4^FRAC_BITS
// ---------------------------------------------------------------------------
module sqrt_pipelined_stream #(
  parameter int  INPUT_BITS  = 16,
  parameter int  FRAC_BITS   = 0,
  localparam int OUTPUT_BITS = (INPUT_BITS + 1) / 2 + FRAC_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_BITS-1:0]  radicand,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUTPUT_BITS-1:0] root,
  output logic [OUTPUT_BITS:0]   remainder
);

  localparam int N  = OUTPUT_BITS;
  localparam int RW = N + 2;   // signed partial remainder width
  localparam int XW = 2 * N;   // scaled, even-width radicand

  // One shared advance enable for every stage.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage i holds the state after i root bits have been resolved.
  logic [N-1:0]         vld_p;
  logic signed [RW-1:0] rem_p [N];
  logic [N-1:0]         q_p   [N];
  logic [XW-1:0]        x_p   [N];

  logic signed [RW-1:0] rem_nx [N];
  logic [N-1:0]         q_nx   [N];
  logic [XW-1:0]        x_nx   [N];
  logic [XW-1:0]        x_load;
  logic [N-1:0]         t_fin;
  logic [N:0]           rem_fin;

  // One non-restoring step: bring in the next radicand bit pair, then subtract
  // (4q+1) when the running remainder is non-negative, otherwise add (4q+3).
  // The left shift may wrap transiently; the two's-complement result of the
  // add/subtract always lands back inside RW bits.
  function automatic logic signed [RW-1:0] rem_step(
    input logic signed [RW-1:0] r,
    input logic [N-1:0]         q,
    input logic [1:0]           pair
  );
    logic signed [RW-1:0] sh;
    sh = $signed({r[RW-3:0], pair});
    if (r[RW-1]) return sh + $signed({q, 2'b11});
    else         return sh - $signed({q, 2'b01});
  endfunction

  // A negative final remainder is restored by adding 2T+1; the result is
  // then non-negative and at most 2T, so it fits in N+1 bits.
  function automatic logic [N:0] rem_fix(
    input logic signed [RW-1:0] r,
    input logic [N-1:0]         t
  );
    logic signed [RW-1:0] c;
    c = r[RW-1] ? (r + $signed({1'b0, t, 1'b1})) : r;
    return (N+1)'(c);
  endfunction

`ifdef SQRT_PIPELINED_ROUND_EN
  // Round to nearest: sqrt(X) >= T+0.5 exactly when X - T*T > T.
  function automatic logic [N-1:0] round_root(
    input logic [N-1:0] t,
    input logic [N:0]   rem
  );
    if ((rem > {1'b0, t}) && (t != '1)) return t + N'(1);
    else                                return t;
  endfunction
`endif

  always_comb begin
    x_load = '0;
    x_load[INPUT_BITS-1:0] = radicand;
    x_load = x_load << (2 * FRAC_BITS);
    for (int i = 0; i < N; i++) begin
      rem_nx[i] = rem_step(rem_p[i], q_p[i], x_p[i][XW-1 -: 2]);
      q_nx[i]   = (q_p[i] << 1) | N'(!rem_nx[i][RW-1]);
      x_nx[i]   = x_p[i] << 2;
    end
    t_fin   = q_nx[N-1];
    rem_fin = rem_fix(rem_nx[N-1], q_nx[N-1]);
  end

  // ---- stage 0 load / stage i -> i+1 datapath ----
  always_ff @(posedge clk) begin
    if (adv) begin
      rem_p[0] <= '0;
      q_p[0]   <= '0;
      x_p[0]   <= x_load;
      for (int i = 1; i < N; i++) begin
        rem_p[i] <= rem_nx[i-1];
        q_p[i]   <= q_nx[i-1];
        x_p[i]   <= x_nx[i-1];
      end
    end
  end

`ifdef SQRT_PIPELINED_ROUND_EN
  logic         vld_pr;
  logic [N-1:0] t_pr;
  logic [N:0]   rem_pr;

  // ---- last recurrence stage -> rounding stage ----
  always_ff @(posedge clk) begin
    if (adv && vld_p[N-1]) begin
      t_pr   <= t_fin;
      rem_pr <= rem_fin;
    end
  end
`endif

  // ---- valid chain and output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p     <= '0;
      out_valid <= 1'b0;
      root      <= '0;
      remainder <= '0;
`ifdef SQRT_PIPELINED_ROUND_EN
      vld_pr    <= 1'b0;
`endif
    end else if (adv) begin
      vld_p[0] <= in_valid;
      for (int i = 1; i < N; i++) vld_p[i] <= vld_p[i-1];
`ifdef SQRT_PIPELINED_ROUND_EN
      vld_pr    <= vld_p[N-1];
      out_valid <= vld_pr;
      if (vld_pr) begin
        root      <= round_root(t_pr, rem_pr);
        remainder <= rem_pr;
      end
`else
      out_valid <= vld_p[N-1];
      if (vld_p[N-1]) begin
        root      <= t_fin;
        remainder <= rem_fin;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sqrt_pipelined_stream.sv
`timescale 1ns/1ps
module tb_sqrt_pipelined_stream;

  localparam int OB  = 8;    // INPUT_BITS=16, FRAC_BITS=0
  localparam int FOB = 12;   // INPUT_BITS=16, FRAC_BITS=4
`ifdef SQRT_PIPELINED_ROUND_EN
  localparam bit RND      = 1'b1;
  localparam int EXP_211  = 15;
  localparam int EXP_F2   = 23;
`else
  localparam bit RND      = 1'b0;
  localparam int EXP_211  = 14;
  localparam int EXP_F2   = 22;
`endif
  localparam int LAT  = OB + (RND ? 1 : 0);
  localparam int FLAT = FOB + (RND ? 1 : 0);

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] radicand;
  logic [7:0]  root;
  logic [8:0]  remainder;

  logic        f_in_valid, f_in_ready, f_out_valid;
  logic [15:0] f_radicand;
  logic [11:0] f_root;
  logic [12:0] f_remainder;

  sqrt_pipelined_stream #(.INPUT_BITS(16), .FRAC_BITS(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .radicand(radicand), .out_valid(out_valid), .out_ready(out_ready),
    .root(root), .remainder(remainder));

  sqrt_pipelined_stream #(.INPUT_BITS(16), .FRAC_BITS(4)) u_frac (
    .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .radicand(f_radicand), .out_valid(f_out_valid), .out_ready(1'b1),
    .root(f_root), .remainder(f_remainder));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint isqrt(input longint x);
    longint t = 0;
    while ((t + 1) * (t + 1) <= x) t++;
    return t;
  endfunction

  function automatic longint model_root(input longint x, input int nbits);
    longint t, r, top;
    t   = isqrt(x);
    r   = x - t * t;
    top = (longint'(1) << nbits) - 1;
    if (RND && r > t) t = (t + 1 > top) ? top : t + 1;
    return t;
  endfunction

  function automatic longint model_rem(input longint x);
    longint t = isqrt(x);
    return x - t * t;
  endfunction

  typedef struct {
    longint rt;
    longint rm;
    int     acc;
    int     s0;
  } exp_t;

  exp_t   sb[$];
  exp_t   e_new;
  longint log_rt[$];
  longint log_rm[$];
  int     cyc = 0;
  int     stalls = 0;
  bit     head_seen = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard / compare process: everything sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb.delete();
      head_seen = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got root %0d with nothing pending (t=%0t)", root, $time);
        end else begin
          check("root", root, sb[0].rt);
          check("remainder", remainder, sb[0].rm);
          if (!head_seen) begin
            // latency grows by one for every cycle the pipeline was frozen
            check("latency_cycle", cyc, sb[0].acc + LAT + (stalls - sb[0].s0));
            head_seen = 1'b1;
          end
          if (out_ready) begin
            log_rt.push_back(root);
            log_rm.push_back(remainder);
            void'(sb.pop_front());
            head_seen = 1'b0;
          end
        end
        if (!out_ready) stalls++;
      end
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (in_valid && in_ready) begin
        e_new.rt  = model_root(longint'(radicand), OB);
        e_new.rm  = model_rem(longint'(radicand));
        e_new.acc = cyc + 1;
        e_new.s0  = stalls;
        sb.push_back(e_new);
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send(input logic [15:0] v);
    bit acc;
    in_valid = 1'b1;
    radicand = v;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL send_timeout: radicand %0d never accepted", v);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int g = 0; g < 400; g++) begin
      if (sb.size() == 0 && !out_valid) return;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL drain_timeout: %0d results still pending", sb.size());
  endtask

  task automatic frac_case(input logic [15:0] v, input longint exp_rt, input longint exp_rm);
    int c;
    f_in_valid = 1'b1;
    f_radicand = v;
    @(posedge clk);
    #1;
    f_in_valid = 1'b0;
    c = 0;
    while (c < 40) begin
      @(negedge clk);
      c++;
      if (f_out_valid) break;
    end
    check("frac_latency", c - 1, FLAT);
    check("frac_root", f_root, exp_rt);
    check("frac_remainder", f_remainder, exp_rm);
    @(posedge clk);
    #1;
  endtask

  int vals[20];
  int n_sent;

  initial begin
    rst = 1'b1; in_valid = 1'b0; radicand = '0; out_ready = 1'b1;
    f_in_valid = 1'b0; f_radicand = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_root", root, 0);
    check("reset_remainder", remainder, 0);

    // pin the model with hand-computed values
    check("model_root_200", model_root(200, OB), 14);
    check("model_rem_200", model_rem(200), 4);
    check("model_root_65535", model_root(65535, OB), 255);
    check("model_rem_65535", model_rem(65535), 510);
    check("model_root_211", model_root(211, OB), EXP_211);

    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // back-to-back 0 / 200 / 65535
    log_rt.delete(); log_rm.delete();
    send(16'd0); send(16'd200); send(16'd65535);
    drain();
    check("b2b_count", log_rt.size(), 3);
    if (log_rt.size() == 3) begin
      check("b2b_root0", log_rt[0], 0);   check("b2b_rem0", log_rm[0], 0);
      check("b2b_root1", log_rt[1], 14);  check("b2b_rem1", log_rm[1], 4);
      check("b2b_root2", log_rt[2], 255); check("b2b_rem2", log_rm[2], 510);
    end

    // rounding boundary values
    log_rt.delete(); log_rm.delete();
    send(16'd210); send(16'd211); send(16'd65535);
    drain();
    check("rnd_count", log_rt.size(), 3);
    if (log_rt.size() == 3) begin
      check("rnd_root210", log_rt[0], 14);      check("rnd_rem210", log_rm[0], 14);
      check("rnd_root211", log_rt[1], EXP_211); check("rnd_rem211", log_rm[1], 15);
      check("rnd_root65535", log_rt[2], 255);   check("rnd_rem65535", log_rm[2], 510);
    end

    // 20 random inputs with a 5-cycle consumer stall mid-stream
    for (int k = 0; k < 20; k++) vals[k] = int'($urandom_range(0, 65535));
    log_rt.delete(); log_rm.delete();
    fork
      begin
        for (int k = 0; k < 20; k++) send(16'(vals[k]));
        in_valid = 1'b0;
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
          #1;
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_count", log_rt.size(), 20);
    if (log_rt.size() == 20)
      for (int k = 0; k < 20; k++) check("stall_order", log_rt[k], model_root(longint'(vals[k]), OB));

    // reset with four results in flight
    send(16'd1000); send(16'd2000); send(16'd3000); send(16'd4000);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_root", root, 0);
    check("midreset_remainder", remainder, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("post_reset_idle", out_valid, 0);
    end
    @(posedge clk);
    #1;
    log_rt.delete(); log_rm.delete();
    send(16'd144);
    drain();
    check("post_reset_count", log_rt.size(), 1);
    if (log_rt.size() == 1) begin
      check("post_reset_root", log_rt[0], 12);
      check("post_reset_rem", log_rm[0], 0);
    end

    // full-rate sweep: low range, every perfect-square boundary, high range
    log_rt.delete(); log_rm.delete();
    n_sent = 0;
    for (int v = 0; v < 4096; v++) begin send(16'(v)); n_sent++; end
    for (int k = 65; k < 256; k++) begin
      send(16'(k * k - 1)); send(16'(k * k)); n_sent += 2;
    end
    for (int v = 61440; v < 65536; v++) begin send(16'(v)); n_sent++; end
    drain();
    check("sweep_count", log_rt.size(), n_sent);

    // fractional instance (FRAC_BITS=4)
    frac_case(16'd2, EXP_F2, 28);
    frac_case(16'd0, 0, 0);
    frac_case(16'd65535, model_root(longint'(65535) << 8, FOB), model_rem(longint'(65535) << 8));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
